// File: rtl/reg_bank_ctrl_pkg.sv
// Shared types and constants for the register bank access controller.
// Holds the controller state encoding, requester IDs and default widths.
package reg_bank_ctrl_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 16;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Converts a requester ID into its one-hot grant vector.
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/reg_bank_ctrl_if.sv
// Request/response bundle between the two requesters and the bank controller.
// Requester i owns bit i of each 2-bit vector and slice i of each packed field.
interface reg_bank_ctrl_if
  import reg_bank_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // request fields stay stable while valid && !ready, and valid may drop before
  // acceptance. A response transfers when rsp_valid && rsp_ready; rsp_id and
  // rsp_data are held stable while rsp_valid && !rsp_ready.
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_waddr;
  logic [2*ADDR_W-1:0] req_raddr1;
  logic [2*ADDR_W-1:0] req_raddr2;
  logic [2*DATA_W-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_data1;
  logic [DATA_W-1:0]   rsp_data2;

  modport master (
    output req_valid, req_write, req_waddr, req_raddr1, req_raddr2, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_write, req_waddr, req_raddr1, req_raddr2, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );

endinterface

// File: rtl/reg_bank_ctrl_rr_arb2.sv
// Two-input arbiter: round-robin, or fixed priority to requester 0.
// Emits a one-hot grant; the round-robin pointer moves only on an enabled grant.
module rr_arb2
  import reg_bank_ctrl_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       gnt_any
);

  // ptr_q names the requester that wins the next tie.
  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (PRIO_FIXED) begin
      if (req[0])      gnt = id_to_onehot(REQ_CORE);
      else if (req[1]) gnt = id_to_onehot(REQ_LOAD);
    end else begin
      case (req)
        2'b01:   gnt = id_to_onehot(REQ_CORE);
        2'b10:   gnt = id_to_onehot(REQ_LOAD);
        2'b11:   gnt = id_to_onehot(ptr_q);
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_id  = gnt[1];
  assign gnt_any = |gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= REQ_CORE;
    end else if (update_en && gnt_any) begin
      ptr_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Access controller in front of the register bank: arbitrates two requesters,
// returns read data over a valid/ready channel and sequences a full bank clear.
module reg_bank_ctrl
  import reg_bank_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_bank_ctrl_if.slave    bus,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              bank_read,
  output logic              bank_write,
  output logic [ADDR_W-1:0] bank_write_port,
  output logic [ADDR_W-1:0] bank_read_port1,
  output logic [ADDR_W-1:0] bank_read_port2,
  output logic [DATA_W-1:0] bank_write_data,
  input  logic [DATA_W-1:0] bank_read_data1,
  input  logic [DATA_W-1:0] bank_read_data2,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic              clr_pending_q, clr_pending_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data2_q;
  logic              rsp_load;

  logic              grant_en;
  logic [1:0]        gnt;
  logic              gnt_id;
  logic              gnt_any;

  logic              win_write;
  logic [ADDR_W-1:0] win_waddr, win_raddr1, win_raddr2;
  logic [DATA_W-1:0] win_wdata;

  // A pending clear blocks grants so the clear starts ahead of any new request.
  assign grant_en = (state_q == IDLE) && !clr_pending_q;

  rr_arb2 #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.req_valid & {2{grant_en}}),
    .update_en (grant_en),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_any   (gnt_any)
  );

  assign win_write  = gnt_id ? bus.req_write[1] : bus.req_write[0];
  assign win_waddr  = gnt_id ? bus.req_waddr[2*ADDR_W-1:ADDR_W]  : bus.req_waddr[ADDR_W-1:0];
  assign win_raddr1 = gnt_id ? bus.req_raddr1[2*ADDR_W-1:ADDR_W] : bus.req_raddr1[ADDR_W-1:0];
  assign win_raddr2 = gnt_id ? bus.req_raddr2[2*ADDR_W-1:ADDR_W] : bus.req_raddr2[ADDR_W-1:0];
  assign win_wdata  = gnt_id ? bus.req_wdata[2*DATA_W-1:DATA_W]  : bus.req_wdata[DATA_W-1:0];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rsp_load        = 1'b0;
    bank_read       = 1'b0;
    bank_write      = 1'b0;
    bank_write_port = '0;
    bank_read_port1 = '0;
    bank_read_port2 = '0;
    bank_write_data = '0;
    case (state_q)
      IDLE: begin
        if (clr_pending_q) begin
          state_d = CLEAR;
        end else if (gnt_any) begin
          if (win_write) begin
            bank_write      = 1'b1;
            bank_write_port = win_waddr;
            bank_write_data = win_wdata;
          end else begin
            // Bank latches on this cycle's negedge; data is captured at the posedge.
            bank_read       = 1'b1;
            bank_read_port1 = win_raddr1;
            bank_read_port2 = win_raddr2;
            rsp_load        = 1'b1;
            state_d         = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      CLEAR: begin
        bank_write      = 1'b1;
        bank_write_port = cnt_q;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new pulse always survives, even on the cycle a previous one is consumed.
  assign clr_pending_d = clr_start || (clr_pending_q && (state_q != IDLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      clr_pending_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_pending_q <= clr_pending_d;
      cnt_q         <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_CORE;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else if (rsp_load) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_data1_q <= bank_read_data1;
      rsp_data2_q <= bank_read_data2;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;
  assign clr_busy      = (state_q == CLEAR);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl with a behavioural 16x32 bank (reset value r[i]=i)
// and a second fixed-priority instance sharing the same request stimulus.
module tb_reg_bank_ctrl;
  import reg_bank_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          clr_start;
  logic          clr_busy, bank_read, bank_write;
  logic [AW-1:0] bank_write_port, bank_read_port1, bank_read_port2;
  logic [DW-1:0] bank_write_data, rd1, rd2;
  state_t        dbg_state;

  reg_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fx ();

  reg_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .PRIO_FIXED(1'b0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .clr_start       (clr_start),
    .clr_busy        (clr_busy),
    .bank_read       (bank_read),
    .bank_write      (bank_write),
    .bank_write_port (bank_write_port),
    .bank_read_port1 (bank_read_port1),
    .bank_read_port2 (bank_read_port2),
    .bank_write_data (bank_write_data),
    .bank_read_data1 (rd1),
    .bank_read_data2 (rd2),
    .dbg_state       (dbg_state)
  );

  // Fixed-priority instance: same requests, its bank side is observed only for grants.
  logic          fx_clr_busy, fx_bank_read, fx_bank_write;
  logic [AW-1:0] fx_wport, fx_rport1, fx_rport2;
  logic [DW-1:0] fx_wdata;
  state_t        fx_state;

  assign bus_fx.req_valid  = bus.req_valid;
  assign bus_fx.req_write  = bus.req_write;
  assign bus_fx.req_waddr  = bus.req_waddr;
  assign bus_fx.req_raddr1 = bus.req_raddr1;
  assign bus_fx.req_raddr2 = bus.req_raddr2;
  assign bus_fx.req_wdata  = bus.req_wdata;
  assign bus_fx.rsp_ready  = bus.rsp_ready;

  reg_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .PRIO_FIXED(1'b1)) dut_fx (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus_fx),
    .clr_start       (1'b0),
    .clr_busy        (fx_clr_busy),
    .bank_read       (fx_bank_read),
    .bank_write      (fx_bank_write),
    .bank_write_port (fx_wport),
    .bank_read_port1 (fx_rport1),
    .bank_read_port2 (fx_rport2),
    .bank_write_data (fx_wdata),
    .bank_read_data1 (rd1),
    .bank_read_data2 (rd2),
    .dbg_state       (fx_state)
  );

  // ---------------- bank model ----------------
  logic [DW-1:0] mem [16];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(i);
    end else if (bank_write) begin
      mem[bank_write_port] <= bank_write_data;
    end
  end

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1 <= '0;
      rd2 <= '0;
    end else if (bank_read) begin
      rd1 <= mem[bank_read_port1];
      rd2 <= mem[bank_read_port2];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [1:0] vld, input logic [7:0] ra1, input logic [7:0] ra2);
    bus.req_valid  = vld;
    bus.req_write  = 2'b00;
    bus.req_raddr1 = ra1;
    bus.req_raddr2 = ra2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] exp_d1;
    logic          exp_id;

    reset_n        = 1'b0;
    clr_start      = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_write  = 2'b00;
    bus.req_waddr  = '0;
    bus.req_raddr1 = '0;
    bus.req_raddr2 = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;

    repeat (2) tick();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data1", bus.rsp_data1, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_bank_write", bank_write, 0);
    tick();
    reset_n = 1'b1;

    // Requester 0 writes r5 = DEADBEEF.
    tick();
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_waddr = {4'd0, 4'd5};
    bus.req_wdata = {32'h0, 32'hDEADBEEF};
    #1;
    chk("wr_ready", bus.req_ready, 2'b01);
    chk("wr_en", bank_write, 1);
    chk("wr_port", bank_write_port, 5);
    chk("wr_data", bank_write_data, 32'hDEADBEEF);
    chk("wr_no_read", bank_read, 0);

    // Requester 0 reads r5/r3.
    tick();
    chk("wr_state_idle", dbg_state, IDLE);
    drive_read(2'b01, {4'd0, 4'd5}, {4'd0, 4'd3});
    #1;
    chk("rd_ready", bus.req_ready, 2'b01);
    chk("rd_en", bank_read, 1);
    chk("rd_wr_low", bank_write, 0);
    chk("rd_port1", bank_read_port1, 5);
    chk("rd_port2", bank_read_port2, 3);

    // Response held for 5 cycles while both requesters wait.
    tick();
    drive_read(2'b11, {4'd7, 4'd5}, {4'd1, 4'd3});
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      chk("stall_state", dbg_state, RESP);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_data1", bus.rsp_data1, 32'hDEADBEEF);
      chk("stall_data2", bus.rsp_data2, 32'h3);
      chk("stall_id", bus.rsp_id, 0);
      #1;
      chk("stall_no_grant", bus.req_ready, 2'b00);
      chk("stall_no_read", bank_read, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("resume_state", dbg_state, IDLE);
    chk("resume_valid", bus.rsp_valid, 0);

    // Contention: last grant went to 0, so round-robin starts with 1.
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    while (exp_q.size() > 0) begin
      exp_id = exp_q.pop_front() != 0;
      exp_d1 = exp_id ? 32'd7 : 32'hDEADBEEF;
      #1;
      chk("rr_grant", bus.req_ready, exp_id ? 2'b10 : 2'b01);
      chk("fx_grant", bus_fx.req_ready, 2'b01);
      tick();
      chk("rr_rsp_valid", bus.rsp_valid, 1);
      chk("rr_rsp_id", bus.rsp_id, exp_id);
      chk("rr_rsp_data1", bus.rsp_data1, exp_d1);
      chk("rr_rsp_data2", bus.rsp_data2, exp_id ? 32'd1 : 32'd3);
      chk("fx_rsp_id", bus_fx.rsp_id, 0);
      tick();
      chk("rr_back_idle", dbg_state, IDLE);
    end
    bus.req_valid = 2'b00;

    // Read r9/r5, pulse clr_start during the response.
    tick();
    drive_read(2'b01, {4'd0, 4'd9}, {4'd0, 4'd5});
    bus.rsp_ready = 1'b0;
    #1;
    chk("r9_ready", bus.req_ready, 2'b01);
    tick();
    chk("r9_data1", bus.rsp_data1, 32'd9);
    chk("r9_data2", bus.rsp_data2, 32'hDEADBEEF);
    bus.req_valid = 2'b00;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr_wait_resp", dbg_state, RESP);
    bus.rsp_ready = 1'b1;
    tick();
    chk("clr_pend_idle", dbg_state, IDLE);
    drive_read(2'b01, {4'd0, 4'd9}, {4'd0, 4'd5});
    #1;
    chk("clr_prio_no_grant", bus.req_ready, 2'b00);
    chk("clr_prio_no_read", bank_read, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("clr_busy", clr_busy, 1);
      chk("clr_wr", bank_write, 1);
      chk("clr_port", bank_write_port, i);
      chk("clr_data", bank_write_data, 0);
      chk("clr_stall", bus.req_ready, 2'b00);
    end
    tick();
    chk("clr_done_busy", clr_busy, 0);
    chk("clr_done_state", dbg_state, IDLE);
    #1;
    chk("post_clr_grant", bus.req_ready, 2'b01);
    tick();
    chk("post_clr_r9", bus.rsp_data1, 0);
    chk("post_clr_r5", bus.rsp_data2, 0);
    bus.req_valid = 2'b00;
    tick();

    // Requester 1 writes r2=0x55, requester 0 reads it on the next grant.
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_waddr = {4'd2, 4'd0};
    bus.req_wdata = {32'h55, 32'h0};
    #1;
    chk("w1_ready", bus.req_ready, 2'b10);
    chk("w1_port", bank_write_port, 2);
    chk("w1_data", bank_write_data, 32'h55);
    tick();
    drive_read(2'b01, {4'd0, 4'd2}, {4'd0, 4'd5});
    #1;
    chk("raw_ready", bus.req_ready, 2'b01);
    tick();
    chk("raw_data1", bus.rsp_data1, 32'h55);
    chk("raw_data2", bus.rsp_data2, 0);
    chk("raw_id", bus.rsp_id, 0);
    bus.req_valid = 2'b00;
    tick();

    // Reset in the middle of a clear at counter 7.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (8) tick();
    chk("mid_clr_state", dbg_state, CLEAR);
    chk("mid_clr_port", bank_write_port, 7);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_clr_rst_state", dbg_state, IDLE);
    chk("mid_clr_rst_busy", clr_busy, 0);
    chk("mid_clr_rst_wr", bank_write, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_clr_after1", dbg_state, IDLE);
    tick();
    chk("mid_clr_no_pend", dbg_state, IDLE);
    chk("mid_clr_no_busy", clr_busy, 0);

    // Reset in the middle of a response owned by requester 1.
    drive_read(2'b10, {4'd6, 4'd0}, {4'd2, 4'd0});
    bus.rsp_ready = 1'b0;
    #1;
    chk("mid_rsp_ready", bus.req_ready, 2'b10);
    tick();
    chk("mid_rsp_valid", bus.rsp_valid, 1);
    chk("mid_rsp_id", bus.rsp_id, 1);
    chk("mid_rsp_data1", bus.rsp_data1, 32'd6);
    chk("mid_rsp_data2", bus.rsp_data2, 32'd2);
    bus.req_valid = 2'b00;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rsp_rst_valid", bus.rsp_valid, 0);
    chk("mid_rsp_rst_id", bus.rsp_id, 0);
    chk("mid_rsp_rst_data1", bus.rsp_data1, 0);
    chk("mid_rsp_rst_data2", bus.rsp_data2, 0);
    chk("mid_rsp_rst_state", dbg_state, IDLE);
    tick();
    reset_n = 1'b1;
    tick();
    chk("final_state", dbg_state, IDLE);
    chk("final_valid", bus.rsp_valid, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
